// File: rtl/op_pkg.sv
// Shared definitions for the operation sequencer: FSM encoding, default widths
// and operation codes.
`timescale 1ns/1ps
package op_pkg;

    localparam int W_IN_DEF  = 4;
    localparam int W_OUT_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP0 = 2'd0;
    localparam logic [1:0] OP1 = 2'd1;
    localparam logic [1:0] OP2 = 2'd2;
    localparam logic [1:0] OP3 = 2'd3;

endpackage

// File: rtl/op_sequencer_dec2to4.sv
// 2-to-4 one-hot decoder with enable; drives the op unit enables.
`timescale 1ns/1ps
module dec2to4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        // NOTE: default assignment first so every path drives y; no latch is inferred.
        y = 4'b0000;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Request/result sequencer: registers an operation, enables one op unit for a
// single cycle, captures its result and holds it until the consumer takes it.
`timescale 1ns/1ps
module op_sequencer
    import op_pkg::*;
#(
    parameter int W_IN  = W_IN_DEF,
    parameter int W_OUT = W_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       OP,
    input  logic [W_IN-1:0]  XI,
    input  logic [W_IN-1:0]  YI,
    output logic [W_IN-1:0]  X,
    output logic [W_IN-1:0]  Y,
    output logic [3:0]       H,
    input  logic [W_OUT-1:0] C,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W_OUT-1:0] R,
    output logic [1:0]       R_OP,
    output logic [7:0]       ops_done
);

    state_t     state;
    logic [1:0] op_q;

    // HOLD forwards res_ready so a retiring result and a new request share an edge.
    assign req_ready = !rst && ((state == S_IDLE) || ((state == S_HOLD) && res_ready));

    dec2to4 u_dec (
        .sel (op_q),
        .en  (state == S_EXEC),
        .y   (H)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: every register here is a plain flop (no memory arrays), so all
            // of them are reset and an in-flight request is simply dropped.
            state     <= S_IDLE;
            op_q      <= OP0;
            X         <= '0;
            Y         <= '0;
            R         <= '0;
            R_OP      <= OP0;
            res_valid <= 1'b0;
            ops_done  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q  <= OP;
                        X     <= XI;
                        Y     <= YI;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    R         <= C;
                    R_OP      <= op_q;
                    res_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ops_done  <= ops_done + 8'd1;
                        if (req_valid) begin
                            op_q  <= OP;
                            X     <= XI;
                            Y     <= YI;
                            state <= S_EXEC;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer with four behavioural op units ORed onto C.
`timescale 1ns/1ps
module tb_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] OP;
    logic [3:0] XI, YI, X, Y, H;
    logic [7:0] C, R, ops_done;
    logic       res_valid, res_ready;
    logic [1:0] R_OP;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    always #5 clk = ~clk;

    op_sequencer #(.W_IN(4), .W_OUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .OP        (OP),
        .XI        (XI),
        .YI        (YI),
        .X         (X),
        .Y         (Y),
        .H         (H),
        .C         (C),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .R         (R),
        .R_OP      (R_OP),
        .ops_done  (ops_done)
    );

    // op0: X+Y, op1: X*Y, op2: X*X+Y, op3: Y^3 (all mod 256); disabled units drive 0.
    logic [7:0] x8, y8, c0, c1, c2, c3;
    assign x8 = {4'b0000, X};
    assign y8 = {4'b0000, Y};
    assign c0 = H[0] ? x8 + y8 : 8'd0;
    assign c1 = H[1] ? x8 * y8 : 8'd0;
    assign c2 = H[2] ? x8 * x8 + y8 : 8'd0;
    assign c3 = H[3] ? y8 * y8 * y8 : 8'd0;
    assign C  = c0 | c1 | c2 | c3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single request from IDLE with res_ready held high.
    task automatic run_one(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                           input logic [7:0] exp);
        OP = op; XI = x; YI = y; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("exec_H",     32'(H),         32'(4'b0001 << op));
        check("exec_X",     32'(X),         32'(x));
        check("exec_Y",     32'(Y),         32'(y));
        check("exec_rv",    32'(res_valid), 32'(1'b0));
        check("exec_rdy",   32'(req_ready), 32'(1'b0));
        tick();
        check("hold_H",     32'(H),         32'(4'b0000));
        check("hold_rv",    32'(res_valid), 32'(1'b1));
        check("hold_R",     32'(R),         32'(exp));
        check("hold_R_OP",  32'(R_OP),      32'(op));
        check("hold_rdy",   32'(req_ready), 32'(1'b1));
        tick();
        exp_done++;
        check("done_rv",    32'(res_valid), 32'(1'b0));
        check("done_cnt",   32'(ops_done),  32'(exp_done[7:0]));
        check("idle_rdy",   32'(req_ready), 32'(1'b1));
    endtask

    logic [1:0] bb_op  [4];
    logic [3:0] bb_x   [4];
    logic [3:0] bb_y   [4];
    logic [7:0] bb_exp [4];

    initial begin
        bb_op[0] = 2'd0; bb_x[0] = 4'd9;  bb_y[0] = 4'd8;  bb_exp[0] = 8'd17;
        bb_op[1] = 2'd1; bb_x[1] = 4'd15; bb_y[1] = 4'd15; bb_exp[1] = 8'd225;
        bb_op[2] = 2'd3; bb_x[2] = 4'd6;  bb_y[2] = 4'd7;  bb_exp[2] = 8'd87;
        bb_op[3] = 2'd0; bb_x[3] = 4'd15; bb_y[3] = 4'd15; bb_exp[3] = 8'd30;

        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0; OP = 2'd0; XI = 4'd0; YI = 4'd0;
        tick();
        tick();
        check("rst_H",     32'(H),         32'(4'b0000));
        check("rst_X",     32'(X),         32'(4'd0));
        check("rst_Y",     32'(Y),         32'(4'd0));
        check("rst_R",     32'(R),         32'(8'd0));
        check("rst_R_OP",  32'(R_OP),      32'(2'd0));
        check("rst_rv",    32'(res_valid), 32'(1'b0));
        check("rst_cnt",   32'(ops_done),  32'(8'd0));
        check("rst_rdy",   32'(req_ready), 32'(1'b0));
        rst = 1'b0;
        #1;
        check("rel_rdy",   32'(req_ready), 32'(1'b1));

        res_ready = 1'b1;
        run_one(2'd3, 4'd0, 4'd3,  8'd27);
        run_one(2'd3, 4'd0, 4'd15, 8'd47);
        run_one(2'd1, 4'd12, 4'd11, 8'd132);

        // Backpressure: result held 5 cycles while a new request waits.
        res_ready = 1'b0;
        OP = 2'd2; XI = 4'd5; YI = 4'd3; req_valid = 1'b1;
        tick();
        OP = 2'd1; XI = 4'd12; YI = 4'd11;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_R",     32'(R),         32'(8'd28));
            check("bp_R_OP",  32'(R_OP),      32'(2'd2));
            check("bp_rv",    32'(res_valid), 32'(1'b1));
            check("bp_rdy",   32'(req_ready), 32'(1'b0));
            check("bp_H",     32'(H),         32'(4'b0000));
            check("bp_X",     32'(X),         32'(4'd5));
            check("bp_cnt",   32'(ops_done),  32'(exp_done[7:0]));
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("bp_rdy_fwd", 32'(req_ready), 32'(1'b1));
        tick();
        exp_done++;
        check("bp_cnt_inc", 32'(ops_done),  32'(exp_done[7:0]));
        check("bp_next_H",  32'(H),         32'(4'b0010));
        check("bp_next_X",  32'(X),         32'(4'd12));
        check("bp_next_Y",  32'(Y),         32'(4'd11));
        check("bp_next_rv", 32'(res_valid), 32'(1'b0));
        req_valid = 1'b0;
        tick();
        check("bp2_R",      32'(R),         32'(8'd132));
        check("bp2_R_OP",   32'(R_OP),      32'(2'd1));
        tick();
        exp_done++;
        check("bp2_cnt",    32'(ops_done),  32'(exp_done[7:0]));

        // Back-to-back: req_valid held high, one result every two cycles.
        OP = bb_op[0]; XI = bb_x[0]; YI = bb_y[0]; req_valid = 1'b1;
        tick();
        OP = bb_op[1]; XI = bb_x[1]; YI = bb_y[1];
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bb_rv",   32'(res_valid), 32'(1'b1));
            check("bb_R",    32'(R),         32'(bb_exp[i]));
            check("bb_R_OP", 32'(R_OP),      32'(bb_op[i]));
            check("bb_rdy",  32'(req_ready), 32'(1'b1));
            tick();
            exp_done++;
            check("bb_cnt",  32'(ops_done),  32'(exp_done[7:0]));
            if (i < 3) begin
                check("bb_H", 32'(H), 32'(4'b0001 << bb_op[i+1]));
            end else begin
                check("bb_end_H",  32'(H),         32'(4'b0000));
                check("bb_end_rv", 32'(res_valid), 32'(1'b0));
            end
            if (i < 2) begin
                OP = bb_op[i+2]; XI = bb_x[i+2]; YI = bb_y[i+2];
            end else begin
                req_valid = 1'b0;
            end
        end

        // Reset during EXEC discards the request.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        OP = 2'd1; XI = 4'd3; YI = 4'd4; req_valid = 1'b1;
        tick();
        check("mid_H",    32'(H),         32'(4'b0010));
        rst = 1'b1; req_valid = 1'b0;
        tick();
        check("mrst_H",   32'(H),         32'(4'b0000));
        check("mrst_rv",  32'(res_valid), 32'(1'b0));
        check("mrst_cnt", 32'(ops_done),  32'(8'd0));
        check("mrst_X",   32'(X),         32'(4'd0));
        check("mrst_rdy", 32'(req_ready), 32'(1'b0));
        rst = 1'b0;
        #1;
        check("mrel_rdy", 32'(req_ready), 32'(1'b1));
        tick();
        tick();
        check("mrel_rv",  32'(res_valid), 32'(1'b0));
        check("mrel_cnt", 32'(ops_done),  32'(8'd0));

        // Counter wrap: handshake n lands on edge 2n+1 with req_valid/res_ready held.
        OP = 2'd0; XI = 4'd1; YI = 4'd1; req_valid = 1'b1; res_ready = 1'b1;
        repeat (511) @(posedge clk);
        #1;
        check("wrap_255", 32'(ops_done), 32'(8'd255));
        tick();
        tick();
        check("wrap_256", 32'(ops_done), 32'(8'd0));
        tick();
        tick();
        check("wrap_257", 32'(ops_done), 32'(8'd1));
        req_valid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
